jstk2_spi_responder: RTL and testbench
======================================

# jstk2_spi_responder

SPI responder (slave) emulating the PmodJSTK2 joystick: it answers the 5-byte SPI transaction issued by the existing joystick reader. It returns X, Y and button data from its input ports, and captures the command and parameter bytes sent by the initiator. The block sits on the far side of the same PMOD SPI link. It is used as the bench/loopback joystick model and as a synthesizable stand-in when no physical joystick is attached.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages on SCK, CS_n and MOSI before edge detection (≥2).
- DUMMY_BYTE, 8'h00: MISO byte returned after byte 4 of a transaction.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_n  in  1  reset, synchronous, active-low.
- SCK  in  1  SPI clock from initiator, mode 0 (idle low), asynchronous to CLK.
- CS_n  in  1  chip select, active-low, asynchronous.
- MOSI  in  1  initiator data, MSB first.
- MISO  out  1  responder data, MSB first.
- x_val  in  10  X position to report.
- y_val  in  10  Y position to report.
- btn  in  8  button byte to report (bit0 stick button, bit1 trigger).
- rx_cmd  out  8  command byte of the last complete transaction.
- rx_param  out  32  parameter bytes 1..4 of that transaction; byte1 in [31:24].
- rx_valid  out  1  one-cycle pulse: rx_cmd/rx_param updated.
- led_rgb  out  24  {R,G,B}, updated by command 8'h84.

## Operation
- Synchronize SCK, CS_n and MOSI through SYNC_STAGES flops, then detect edges: sck_rise, sck_fall, cs_fall, cs_rise.
- States: IDLE and XFER.
  - IDLE → XFER on cs_fall.
  - XFER → IDLE on cs_rise, or when synchronized CS_n is high.
- On cs_fall, snapshot the tx frame:
  - byte0 = x_val[7:0]
  - byte1 = {6'b0, x_val[9:8]}
  - byte2 = y_val[7:0]
  - byte3 = {6'b0, y_val[9:8]}
  - byte4 = btn
  - Input changes during the transaction are ignored.
- On cs_fall: bit_cnt=0, byte_cnt=0, tx shift register = byte0, MISO = byte0[7].
- On sck_rise in XFER: shift synchronized MOSI into rx_shift, then bit_cnt++.
  - When bit_cnt wraps 7→0: store the byte at index byte_cnt if byte_cnt<5.
  - byte_cnt saturates at 5.
- On sck_fall in XFER: MISO shifts to the next bit.
  - If bit_cnt==0 (byte boundary), load the next tx byte and drive its bit7.
  - At byte_cnt≥5, use DUMMY_BYTE.
- On cs_rise, a transaction is complete when byte_cnt==5 and bit_cnt==0. If complete:
  - Latch rx_cmd and rx_param.
  - Pulse rx_valid.
  - If rx_cmd==8'h84, also set led_rgb = {param1, param2, param3}.
- Incomplete transaction (fewer than 5 bytes, or a partial byte): discard it. No rx_valid; rx_cmd, rx_param and led_rgb are unchanged.
- More than 5 bytes: extra received bytes are discarded; the transaction is still complete if it ends on a byte boundary.
- MISO is driven 0 whenever not in XFER. No tristate; the top level handles bus sharing.
- Reset values: MISO 0, rx_cmd 0, rx_param 0, rx_valid 0, led_rgb 0, state IDLE, all counters 0.

## Timing
- Edge-detect latency: SYNC_STAGES+1 CLK cycles from a pin edge to the internal pulse.
- Requirements on the initiator:
  - SCK high and low phases each ≥ SYNC_STAGES+3 CLK cycles.
  - CS_n falling edge to first SCK rising edge ≥ SYNC_STAGES+3 CLK cycles.
- MISO bit n+1 is valid SYNC_STAGES+2 CLK cycles after the falling SCK edge, well before the next rising edge.
- rx_valid fires SYNC_STAGES+2 CLK cycles after the CS_n pin rises. rx_cmd, rx_param and led_rgb change in the same cycle rx_valid is high.
- Simultaneous cs_rise and sck edge: cs_rise wins and the sck edge is ignored.
- cs_fall while in XFER: restart the frame. Unreachable with a synchronized CS_n; verify by assertion.
- Reset mid-transaction: immediate IDLE. The rest of that transaction is ignored until the next cs_fall.

## Structure
- Shared package jstk2_pkg:
  - JSTK2_PKT_BYTES = 5
  - JSTK2_CMD_SET_LED = 8'h84
  - JSTK2_CMD_READ = 8'hC0
  - byte-index constants
  - The existing joystick reader imports the same package.
- Sub-module spi_sync_edge: parameterized synchronizer plus rising/falling edge pulses. Instantiated three times: SCK, CS_n, MOSI (MOSI uses the level only).
- Top-level wiring to PMOD7–PMOD10 lives outside this block.

## Test plan
- x_val=10'h33A, y_val=10'h0E4, btn=8'h02; 5-byte transaction with MOSI 8'hC0,0,0,0,0 → MISO bytes 3A,03,E4,00,02; rx_valid pulses once; rx_cmd=C0.
- MOSI 84,FF,10,01,00 → led_rgb=24'hFF1001; rx_param=32'hFF100100.
- CS_n raised after 3 bytes → no rx_valid; led_rgb and rx_cmd keep their previous values.
- x_val changed mid-transaction → MISO still returns the values snapshotted at CS_n fall; the next transaction returns the new values.
- 7-byte transaction → bytes 5 and 6 read DUMMY_BYTE (00); rx_valid asserted; rx_param holds bytes 1..4.
- RST_n low during byte 2, then a full transaction → all outputs at their reset values after reset; the following transaction is correct.
- Full transaction through the existing joystick reader against this block → joystick reader x_pos and y_pos equal x_val and y_val.

Source files
------------

// File: rtl/jstk2_pkg.sv
// Shared constants and frame layout for the PmodJSTK2 SPI link.
// Imported by the joystick reader and the responder model.
package jstk2_pkg;

   localparam int         JSTK2_PKT_BYTES   = 5;
   localparam logic [2:0] JSTK2_PKT_CNT     = 3'd5;
   localparam logic [7:0] JSTK2_CMD_SET_LED = 8'h84;
   localparam logic [7:0] JSTK2_CMD_READ    = 8'hC0;

   localparam logic [2:0] BYTE_X_LO = 3'd0;
   localparam logic [2:0] BYTE_X_HI = 3'd1;
   localparam logic [2:0] BYTE_Y_LO = 3'd2;
   localparam logic [2:0] BYTE_Y_HI = 3'd3;
   localparam logic [2:0] BYTE_BTN  = 3'd4;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } jstk2_state_t;

   function automatic logic [7:0] jstk2_frame_byte(
      input logic [9:0] x,
      input logic [9:0] y,
      input logic [7:0] b,
      input logic [2:0] idx
   );
      logic [7:0] r;
      r = 8'h00;
      unique case (idx)
         BYTE_X_LO: r = x[7:0];
         BYTE_X_HI: r = {6'b0, x[9:8]};
         BYTE_Y_LO: r = y[7:0];
         BYTE_Y_HI: r = {6'b0, y[9:8]};
         BYTE_BTN:  r = b;
         default:   r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered edge pulses.
// level is delayed to line up with the rise/fall pulses.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sr;
   logic              prev;

   // No reset: the chain keeps tracking the pin so reset never fakes an edge.
   always_ff @(posedge CLK) begin
      sr   <= {sr[STAGES-2:0], din};
      prev <= sr[STAGES-1];
      rise <= sr[STAGES-1] & ~prev;
      fall <= ~sr[STAGES-1] & prev;
   end

   assign level = prev;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 responder emulating a PmodJSTK2 joystick.
// Returns X/Y/buttons and captures the 5-byte command frame.
module jstk2_spi_responder
   import jstk2_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DUMMY_BYTE  = 8'h00
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        SCK,
   input  logic        CS_n,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [9:0]  x_val,
   input  logic [9:0]  y_val,
   input  logic [7:0]  btn,
   output logic [7:0]  rx_cmd,
   output logic [31:0] rx_param,
   output logic        rx_valid,
   output logic [23:0] led_rgb
);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
      .CLK(CLK), .din(SCK),
      .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
      .CLK(CLK), .din(CS_n),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
      .CLK(CLK), .din(MOSI),
      .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   jstk2_state_t state;
   logic [2:0]   bit_cnt;
   logic [2:0]   byte_cnt;
   logic [7:0]   tx_shift;
   logic [7:0]   rx_shift;
   logic [7:0]   tx_frame [JSTK2_PKT_BYTES];
   logic [7:0]   rx_bytes [JSTK2_PKT_BYTES];

   logic [7:0] byte0;
   logic [7:0] next_tx;
   logic [7:0] rx_byte;
   logic       pkt_done;

   always_comb begin
      byte0    = jstk2_frame_byte(x_val, y_val, btn, BYTE_X_LO);
      next_tx  = DUMMY_BYTE;
      if (byte_cnt < JSTK2_PKT_CNT)
         next_tx = tx_frame[byte_cnt];
      rx_byte  = {rx_shift[6:0], mosi_s};
      pkt_done = (byte_cnt == JSTK2_PKT_CNT) && (bit_cnt == 3'd0);
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state    <= IDLE;
         bit_cnt  <= 3'd0;
         byte_cnt <= 3'd0;
         tx_shift <= 8'h00;
         rx_shift <= 8'h00;
         MISO     <= 1'b0;
         rx_cmd   <= 8'h00;
         rx_param <= 32'h0;
         rx_valid <= 1'b0;
         led_rgb  <= 24'h0;
         for (int i = 0; i < JSTK2_PKT_BYTES; i++) begin
            tx_frame[i] <= 8'h00;
            rx_bytes[i] <= 8'h00;
         end
      end else begin
         rx_valid <= 1'b0;
         if (cs_fall) begin
            state    <= XFER;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
            tx_shift <= byte0;
            MISO     <= byte0[7];
            for (int i = 0; i < JSTK2_PKT_BYTES; i++)
               tx_frame[i] <= jstk2_frame_byte(x_val, y_val, btn, 3'(i));
         end else if (state == XFER) begin
            // CS release takes priority over any coincident SCK edge.
            if (cs_rise || cs_lvl) begin
               state <= IDLE;
               MISO  <= 1'b0;
               if (cs_rise && pkt_done) begin
                  rx_cmd   <= rx_bytes[0];
                  rx_param <= {rx_bytes[1], rx_bytes[2],
                               rx_bytes[3], rx_bytes[4]};
                  rx_valid <= 1'b1;
                  if (rx_bytes[0] == JSTK2_CMD_SET_LED)
                     led_rgb <= {rx_bytes[1], rx_bytes[2], rx_bytes[3]};
               end
            end else if (sck_rise) begin
               rx_shift <= rx_byte;
               bit_cnt  <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (byte_cnt < JSTK2_PKT_CNT) begin
                     rx_bytes[byte_cnt] <= rx_byte;
                     byte_cnt           <= byte_cnt + 3'd1;
                  end
               end
            end else if (sck_fall) begin
               if (bit_cnt == 3'd0) begin
                  tx_shift <= next_tx;
                  MISO     <= next_tx[7];
               end else begin
                  tx_shift <= {tx_shift[6:0], 1'b0};
                  MISO     <= tx_shift[6];
               end
            end
         end
      end
   end

   a_no_restart: assert property (@(posedge CLK) disable iff (!RST_n)
      !(cs_fall && state == XFER));

   a_sck_idle_low: assert property (@(posedge CLK) disable iff (!RST_n)
      cs_fall |-> !sck_lvl);

   a_mosi_setup: assert property (@(posedge CLK) disable iff (!RST_n)
      (state == XFER && sck_rise) |-> !(mosi_rise || mosi_fall));

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Bench for the PmodJSTK2 responder: table-driven frames plus
// hand sequences for mid-frame input change and mid-frame reset.
module tb_jstk2_spi_responder;
   import jstk2_pkg::*;

   localparam int HP = 8;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        SCK = 1'b0;
   logic        CS_n = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic [9:0]  x_val = 10'h0;
   logic [9:0]  y_val = 10'h0;
   logic [7:0]  btn = 8'h0;
   logic [7:0]  rx_cmd;
   logic [31:0] rx_param;
   logic        rx_valid;
   logic [23:0] led_rgb;

   jstk2_spi_responder #(.SYNC_STAGES(2), .DUMMY_BYTE(8'h00)) dut (
      .CLK(CLK), .RST_n(RST_n), .SCK(SCK), .CS_n(CS_n),
      .MOSI(MOSI), .MISO(MISO), .x_val(x_val), .y_val(y_val),
      .btn(btn), .rx_cmd(rx_cmd), .rx_param(rx_param),
      .rx_valid(rx_valid), .led_rgb(led_rgb)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int vcnt = 0;
   logic [7:0] exp_q [$];

   always @(negedge CLK) if (rx_valid) vcnt++;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [7:0]  b;
      logic [55:0] mo;
      int          nbytes;
      int          xbits;
      int          exp_v;
      logic [7:0]  exp_cmd;
      logic [31:0] exp_param;
      logic [23:0] exp_led;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [9:0] x,
      input logic [9:0] y, input logic [7:0] b, input int i);
      case (i)
         0:       return x[7:0];
         1:       return {6'b0, x[9:8]};
         2:       return y[7:0];
         3:       return {6'b0, y[9:8]};
         4:       return b;
         default: return 8'h00;
      endcase
   endfunction

   task automatic cs_low();
      CS_n = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 7; i++)
         exp_q.push_back(model_byte(x_val, y_val, btn, i));
      repeat (HP) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] mo, input int nbits);
      logic [7:0] got;
      logic [7:0] e;
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         MOSI = mo[7-i];
         repeat (HP) @(negedge CLK);
         got[7-i] = MISO;
         SCK = 1'b1;
         repeat (HP) @(negedge CLK);
         SCK = 1'b0;
      end
      if (nbits == 8) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_queue_empty got=%h exp=none", got);
         end else begin
            e = exp_q.pop_front();
            chk("miso_byte", {24'h0, got}, {24'h0, e});
         end
      end
   endtask

   task automatic cs_high(output int pulses);
      int v0;
      v0 = vcnt;
      repeat (HP) @(negedge CLK);
      CS_n = 1'b1;
      repeat (4 * HP) @(negedge CLK);
      pulses = vcnt - v0;
   endtask

   task automatic chk_outs(input string tag, input logic [7:0] c,
      input logic [31:0] p, input logic [23:0] l);
      chk({tag, "_cmd"}, {24'h0, rx_cmd}, {24'h0, c});
      chk({tag, "_param"}, rx_param, p);
      chk({tag, "_led"}, {8'h0, led_rgb}, {8'h0, l});
   endtask

   initial begin
      int pulses;

      vecs[0] = '{10'h33A, 10'h0E4, 8'h02, 56'hC0000000000000,
                  5, 0, 1, 8'hC0, 32'h00000000, 24'h000000};
      vecs[1] = '{10'h33A, 10'h0E4, 8'h02, 56'h84FF1001000000,
                  5, 0, 1, 8'h84, 32'hFF100100, 24'hFF1001};
      vecs[2] = '{10'h2C5, 10'h1F0, 8'h01, 56'hC0112233000000,
                  3, 0, 0, 8'h84, 32'hFF100100, 24'hFF1001};
      vecs[3] = '{10'h100, 10'h200, 8'h03, 56'h84010203040000,
                  5, 3, 0, 8'h84, 32'hFF100100, 24'hFF1001};
      vecs[4] = '{10'h3FF, 10'h000, 8'hFF, 56'hC0112233445566,
                  7, 0, 1, 8'hC0, 32'h11223344, 24'hFF1001};
      vecs[5] = '{10'h001, 10'h3FE, 8'h80, 56'h84AABBCCDD0000,
                  5, 0, 1, 8'h84, 32'hAABBCCDD, 24'hAABBCC};

      repeat (10) @(negedge CLK);
      chk("rst_miso", {31'h0, MISO}, 32'h0);
      chk("rst_valid", {31'h0, rx_valid}, 32'h0);
      chk_outs("rst", 8'h00, 32'h0, 24'h0);
      RST_n = 1'b1;
      repeat (10) @(negedge CLK);
      chk("idle_valid_cnt", vcnt, 0);

      for (int v = 0; v < 6; v++) begin
         x_val = vecs[v].x;
         y_val = vecs[v].y;
         btn   = vecs[v].b;
         cs_low();
         for (int k = 0; k < vecs[v].nbytes; k++)
            send_byte(vecs[v].mo[55-8*k -: 8], 8);
         if (vecs[v].xbits > 0)
            send_byte(vecs[v].mo[55-8*vecs[v].nbytes -: 8],
                      vecs[v].xbits);
         cs_high(pulses);
         chk($sformatf("vec%0d_valid", v), pulses, vecs[v].exp_v);
         chk_outs($sformatf("vec%0d", v), vecs[v].exp_cmd,
                  vecs[v].exp_param, vecs[v].exp_led);
         chk($sformatf("vec%0d_idle_miso", v), {31'h0, MISO}, 32'h0);
      end

      // Input change mid-frame must not disturb the snapshot.
      x_val = 10'h33A;
      y_val = 10'h0E4;
      btn   = 8'h02;
      cs_low();
      send_byte(JSTK2_CMD_READ, 8);
      x_val = 10'h155;
      for (int k = 1; k < 5; k++) send_byte(8'h00, 8);
      cs_high(pulses);
      chk("snap_valid", pulses, 1);
      cs_low();
      chk("snap_new_head", {24'h0, exp_q[0]}, 32'h55);
      send_byte(JSTK2_CMD_READ, 8);
      for (int k = 1; k < 5; k++) send_byte(8'h00, 8);
      cs_high(pulses);
      chk("snap2_valid", pulses, 1);

      // Reset during the second byte, remainder of frame ignored.
      cs_low();
      send_byte(8'h84, 8);
      send_byte(8'h11, 4);
      RST_n = 1'b0;
      repeat (3) @(negedge CLK);
      chk("mrst_miso", {31'h0, MISO}, 32'h0);
      chk_outs("mrst", 8'h00, 32'h0, 24'h0);
      RST_n = 1'b1;
      send_byte(8'h11, 4);
      exp_q.delete();
      for (int k = 0; k < 3; k++) exp_q.push_back(8'h00);
      send_byte(8'h22, 8);
      send_byte(8'h33, 8);
      send_byte(8'h44, 8);
      cs_high(pulses);
      chk("mrst_valid", pulses, 0);
      chk_outs("mrst_after", 8'h00, 32'h0, 24'h0);

      cs_low();
      send_byte(8'h84, 8);
      send_byte(8'h01, 8);
      send_byte(8'h02, 8);
      send_byte(8'h03, 8);
      send_byte(8'h04, 8);
      cs_high(pulses);
      chk("post_rst_valid", pulses, 1);
      chk_outs("post_rst", 8'h84, 32'h01020304, 24'h010203);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
